entrada_bcd: RTL and testbench

Two-digit decimal entry reader for the board pushbuttons: debounces two active-low keys, lets the operator dial a tens digit (0–1) and a units digit (0–9), then validates the entry and emits a binary value 0–15 with a one-cycle load strobe. It sits on the input side of the 4-bit counter/display path. It produces the preset value that the counter loads, and drives the live digits back to the BCD displays during editing.

---
 rtl/entrada_bcd_if.sv | 23 ++
 rtl/entrada_bcd.sv | 164 ++++++++++++++++
 tb/tb_entrada_bcd.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/entrada_bcd_if.sv
// Key inputs and entry outputs of the two-digit decimal entry reader.
// The slave side is the reader itself; the master side drives the keys and
// observes the result.
interface entrada_bcd_if;
  logic       KEY1;
  logic       KEY2;
  logic [3:0] valor;
  logic       carga;
  logic       erro;
  logic [3:0] dezena;
  logic [3:0] unidade;
  logic       editando_uni;

  modport master (
    output KEY1, KEY2,
    input  valor, carga, erro, dezena, unidade, editando_uni
  );

  modport slave (
    input  KEY1, KEY2,
    output valor, carga, erro, dezena, unidade, editando_uni
  );
endinterface

// File: rtl/entrada_bcd.sv
// Two-digit decimal entry reader.
// Debounces two active-low pushbuttons. KEY1 increments the digit being
// edited and KEY2 confirms it. After the units digit is confirmed, the entry
// is validated and emits a 0..15 preset value with a one-cycle load strobe.
module entrada_bcd #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int MAX_VALOR       = 15
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  entrada_bcd_if.slave  bus
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    ST_DEZENA  = 2'd0,
    ST_UNIDADE = 2'd1,
    ST_VALIDA  = 2'd2
  } state_t;

  // Bit 0 is KEY1 (increment) and bit 1 is KEY2 (confirm).
  logic [1:0] key_raw;
  logic [1:0] press_ev;

  assign key_raw = {bus.KEY2, bus.KEY1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
      logic             sync1_reg;
      logic             sync2_reg;
      logic             nivel_reg;
      logic             press_reg;
      logic [CNT_W-1:0] cnt_reg;

      // Synchronise the key, debounce it, and emit a one-cycle pulse when
      // the accepted level falls.
      always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
          nivel_reg <= 1'b1;
          press_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= key_raw[gi];
          sync2_reg <= sync1_reg;
          press_reg <= 1'b0;
          if (sync2_reg == nivel_reg) begin
            // No pending change, so the stability count restarts.
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_MAX) begin
            nivel_reg <= sync2_reg;
            cnt_reg   <= '0;
            // Only the press edge (1 -> 0) is an event; a release is silent.
            press_reg <= ~sync2_reg;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign press_ev[gi] = press_reg;
    end
  endgenerate

  logic inc_ev;
  logic conf_ev;

  assign inc_ev  = press_ev[0];
  assign conf_ev = press_ev[1];

  state_t     state_reg,   state_next;
  logic [3:0] dezena_reg,  dezena_next;
  logic [3:0] unidade_reg, unidade_next;
  logic [3:0] valor_reg,   valor_next;
  logic       carga_reg,   carga_next;
  logic       erro_reg,    erro_next;
  logic [4:0] soma;

  // The tens digit is at most 1, so soma never exceeds 19 and fits in 5 bits.
  assign soma = 5'(dezena_reg) * 5'd10 + 5'(unidade_reg);

  // Register the state, the digits and every output.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_DEZENA;
      dezena_reg  <= '0;
      unidade_reg <= '0;
      valor_reg   <= '0;
      carga_reg   <= 1'b0;
      erro_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      dezena_reg  <= dezena_next;
      unidade_reg <= unidade_next;
      valor_reg   <= valor_next;
      carga_reg   <= carga_next;
      erro_reg    <= erro_next;
    end
  end

  // Compute the next state and outputs.
  // Confirm takes priority over increment, and keys are ignored while validating.
  always_comb begin
    state_next   = state_reg;
    dezena_next  = dezena_reg;
    unidade_next = unidade_reg;
    valor_next   = valor_reg;
    carga_next   = 1'b0;
    erro_next    = erro_reg;

    case (state_reg)
      ST_DEZENA: begin
        if (inc_ev || conf_ev) begin
          erro_next = 1'b0;
        end
        if (conf_ev) begin
          state_next = ST_UNIDADE;
        end else if (inc_ev) begin
          dezena_next = (dezena_reg == 4'd1) ? 4'd0 : dezena_reg + 4'd1;
        end
      end

      ST_UNIDADE: begin
        if (inc_ev || conf_ev) begin
          erro_next = 1'b0;
        end
        if (conf_ev) begin
          state_next = ST_VALIDA;
        end else if (inc_ev) begin
          unidade_next = (unidade_reg == 4'd9) ? 4'd0 : unidade_reg + 4'd1;
        end
      end

      ST_VALIDA: begin
        if (soma <= 5'(MAX_VALOR)) begin
          valor_next = soma[3:0];
          carga_next = 1'b1;
          erro_next  = 1'b0;
        end else begin
          erro_next = 1'b1;
        end
        dezena_next  = '0;
        unidade_next = '0;
        state_next   = ST_DEZENA;
      end

      default: begin
        state_next = ST_DEZENA;
      end
    endcase
  end

  assign bus.valor        = valor_reg;
  assign bus.carga        = carga_reg;
  assign bus.erro         = erro_reg;
  assign bus.dezena       = dezena_reg;
  assign bus.unidade      = unidade_reg;
  assign bus.editando_uni = (state_reg == ST_UNIDADE);

endmodule

// File: tb/tb_entrada_bcd.sv
// Directed testbench for entrada_bcd with a short debounce window.
module tb_entrada_bcd;

  localparam int DEB = 4;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;
  int   carga_cnt;
  int   b2b_cnt;
  logic carga_prev;

  entrada_bcd_if bus ();

  entrada_bcd #(
    .DEBOUNCE_CYCLES (DEB),
    .MAX_VALOR       (15)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count load strobes and flag any strobe that is high on consecutive cycles.
  initial begin
    carga_cnt  = 0;
    b2b_cnt    = 0;
    carga_prev = 1'b0;
  end

  always @(negedge clk) begin
    if (bus.carga === 1'b1) begin
      carga_cnt++;
      if (carga_prev) b2b_cnt++;
    end
    carga_prev = (bus.carga === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_key(input int k, input logic v);
    if (k == 1) bus.KEY1 = v;
    else        bus.KEY2 = v;
  endtask

  task automatic press(input int k);
    set_key(k, 1'b0);
    tick(8);
    set_key(k, 1'b1);
    tick(8);
  endtask

  task automatic press_both();
    bus.KEY1 = 1'b0;
    bus.KEY2 = 1'b0;
    tick(8);
    bus.KEY1 = 1'b1;
    bus.KEY2 = 1'b1;
    tick(8);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.KEY1 = 1'b1;
    bus.KEY2 = 1'b1;
    reset_n  = 1'b0;

    // Reset state.
    tick(3);
    check("rst_valor",   8'(bus.valor),        8'd0);
    check("rst_carga",   8'(bus.carga),        8'd0);
    check("rst_erro",    8'(bus.erro),         8'd0);
    check("rst_dezena",  8'(bus.dezena),       8'd0);
    check("rst_unidade", 8'(bus.unidade),      8'd0);
    check("rst_edit",    8'(bus.editando_uni), 8'd0);
    reset_n = 1'b1;
    tick(20);
    check("idle_no_carga", 8'(carga_cnt), 8'd0);
    $display("step reset: valor=%0d carga_cnt=%0d", bus.valor, carga_cnt);

    // Entry of 12, with the latency of the first increment checked cycle by cycle.
    bus.KEY1 = 1'b0;
    tick(7);
    check("lat_dez_before", 8'(bus.dezena), 8'd0);
    tick(1);
    check("lat_dez_after", 8'(bus.dezena), 8'd1);
    bus.KEY1 = 1'b1;
    tick(8);
    press(2);
    check("edit_uni_on", 8'(bus.editando_uni), 8'd1);
    press(1);
    press(1);
    check("uni_2", 8'(bus.unidade), 8'd2);
    bus.KEY2 = 1'b0;
    tick(7);
    check("conf_ev_still_uni", 8'(bus.editando_uni), 8'd1);
    tick(1);
    check("valida_carga0", 8'(bus.carga),        8'd0);
    check("valida_edit0",  8'(bus.editando_uni), 8'd0);
    tick(1);
    check("load12_carga",   8'(bus.carga),   8'd1);
    check("load12_valor",   8'(bus.valor),   8'd12);
    check("load12_erro",    8'(bus.erro),    8'd0);
    check("load12_dezena",  8'(bus.dezena),  8'd0);
    check("load12_unidade", 8'(bus.unidade), 8'd0);
    tick(1);
    check("load12_carga_off", 8'(bus.carga), 8'd0);
    bus.KEY2 = 1'b1;
    tick(8);
    check("load12_count", 8'(carga_cnt), 8'd1);
    $display("step entry12: valor=%0d carga_cnt=%0d", bus.valor, carga_cnt);

    // Entry of 17 is rejected.
    press(1);
    press(2);
    for (int i = 0; i < 7; i++) press(1);
    check("uni_7", 8'(bus.unidade), 8'd7);
    bus.KEY2 = 1'b0;
    tick(9);
    check("e17_erro",   8'(bus.erro),   8'd1);
    check("e17_carga",  8'(bus.carga),  8'd0);
    check("e17_valor",  8'(bus.valor),  8'd12);
    check("e17_dezena", 8'(bus.dezena), 8'd0);
    bus.KEY2 = 1'b1;
    tick(8);
    check("e17_erro_held", 8'(bus.erro),   8'd1);
    check("e17_no_carga",  8'(carga_cnt),  8'd1);
    press(1);
    check("erro_cleared", 8'(bus.erro),   8'd0);
    check("erro_clr_dez", 8'(bus.dezena), 8'd1);
    $display("step entry17: erro=%0d valor=%0d dezena=%0d", bus.erro, bus.valor, bus.dezena);

    // A bouncing key produces no event; a clean press then increments once.
    for (int i = 0; i < 30; i++) begin
      bus.KEY1 = ((i % 4) < 2) ? 1'b0 : 1'b1;
      tick(1);
    end
    bus.KEY1 = 1'b1;
    tick(10);
    check("bounce_dez", 8'(bus.dezena), 8'd1);
    press(1);
    check("bounce_press", 8'(bus.dezena), 8'd0);
    $display("step bounce: dezena=%0d", bus.dezena);

    // Digit wrap-around, and confirm taking priority over a simultaneous increment.
    press(1);
    check("wrap_dez_1", 8'(bus.dezena), 8'd1);
    press(1);
    check("wrap_dez_0", 8'(bus.dezena), 8'd0);
    press_both();
    check("both_dez_edit", 8'(bus.editando_uni), 8'd1);
    check("both_dez_val",  8'(bus.dezena),       8'd0);
    for (int i = 0; i < 9; i++) press(1);
    check("wrap_uni_9", 8'(bus.unidade), 8'd9);
    press(1);
    check("wrap_uni_0", 8'(bus.unidade), 8'd0);
    for (int i = 0; i < 3; i++) press(1);
    press_both();
    check("both_uni_valor", 8'(bus.valor),   8'd3);
    check("both_uni_count", 8'(carga_cnt),   8'd2);
    check("both_uni_uni",   8'(bus.unidade), 8'd0);
    $display("step wrap/priority: valor=%0d carga_cnt=%0d", bus.valor, carga_cnt);

    // Reset asserted mid-entry clears the outputs immediately and produces no load.
    press(1);
    press(2);
    for (int i = 0; i < 5; i++) press(1);
    check("mid_dezena",  8'(bus.dezena),       8'd1);
    check("mid_unidade", 8'(bus.unidade),      8'd5);
    check("mid_edit",    8'(bus.editando_uni), 8'd1);
    reset_n = 1'b0;
    #1;
    check("async_valor",   8'(bus.valor),        8'd0);
    check("async_dezena",  8'(bus.dezena),       8'd0);
    check("async_unidade", 8'(bus.unidade),      8'd0);
    check("async_edit",    8'(bus.editando_uni), 8'd0);
    tick(3);
    reset_n = 1'b1;
    tick(20);
    check("post_rst_count", 8'(carga_cnt), 8'd2);
    check("post_rst_valor", 8'(bus.valor), 8'd0);
    check("no_back_to_back", 8'(b2b_cnt),  8'd0);
    $display("step midreset: valor=%0d carga_cnt=%0d", bus.valor, carga_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
